// File: rtl/nand_gate_sequencer.sv
// Sequences NOT/AND/OR/XOR as NAND micro-ops on one shared 8-bit NAND unit.
// Define NAND_GATE_SEQUENCER_XOR_EN to run the XOR sequence for op 11.
module nand_gate_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  result,
    output logic        err,
    output logic        busy,
    output logic [15:0] nand_ops
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  step;
    logic [1:0]  op_r;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [7:0]  s1;
    logic [7:0]  s2;
`ifdef NAND_GATE_SEQUENCER_XOR_EN
    logic [7:0]  s3;
`endif
    logic [7:0]  res_r;
    logic        err_r;
    logic [15:0] cnt;
    logic [7:0]  nx;
    logic [7:0]  ny;
    logic [7:0]  nz;
    logic        last;
    logic        nop;

    // Operand routing for the shared NAND, keyed by op and micro-step
    always_comb begin
        nx   = a_r;
        ny   = a_r;
        last = 1'b0;
        nop  = 1'b0;
        case ({op_r, step})
            4'b00_00: last = 1'b1;
            4'b01_00: ny = b_r;
            4'b01_01: begin
                nx   = s1;
                ny   = s1;
                last = 1'b1;
            end
            4'b10_00: ;
            4'b10_01: begin
                nx = b_r;
                ny = b_r;
            end
            4'b10_10: begin
                nx   = s1;
                ny   = s2;
                last = 1'b1;
            end
`ifdef NAND_GATE_SEQUENCER_XOR_EN
            4'b11_00: ny = b_r;
            4'b11_01: ny = s1;
            4'b11_10: begin
                nx = b_r;
                ny = s1;
            end
            4'b11_11: begin
                nx   = s2;
                ny   = s3;
                last = 1'b1;
            end
`else
            4'b11_00: begin
                last = 1'b1;
                nop  = 1'b1;
            end
`endif
            default: last = 1'b1;
        endcase
    end

    assign nz = ~(nx & ny);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= 2'd0;
            op_r  <= 2'd0;
            a_r   <= 8'h00;
            b_r   <= 8'h00;
            s1    <= 8'h00;
            s2    <= 8'h00;
`ifdef NAND_GATE_SEQUENCER_XOR_EN
            s3    <= 8'h00;
`endif
            res_r <= 8'h00;
            err_r <= 1'b0;
            cnt   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        step  <= 2'd0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!nop && cnt != 16'hFFFF)
                        cnt <= cnt + 16'd1;
                    if (last) begin
                        res_r <= nop ? 8'h00 : nz;
                        err_r <= nop;
                        state <= DONE;
                    end else begin
                        step <= step + 2'd1;
                        case (step)
                            2'd0: s1 <= nz;
                            2'd1: s2 <= nz;
`ifdef NAND_GATE_SEQUENCER_XOR_EN
                            2'd2: s3 <= nz;
`endif
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_r;
    assign err       = err_r;
    assign nand_ops  = cnt;

endmodule

// File: tb/tb_nand_gate_sequencer.sv
// Bench for nand_gate_sequencer: behavioural model checked every cycle
// plus directed vectors with literal expectations.
module tb_nand_gate_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result;
    logic        err;
    logic        busy;
    logic [15:0] nand_ops;

    nand_gate_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy),
        .nand_ops  (nand_ops)
    );

    always #5 clk = ~clk;

`ifdef NAND_GATE_SEQUENCER_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_res(input logic [1:0] o,
                                           input logic [7:0] x,
                                           input logic [7:0] y);
        case (o)
            2'd0:    return ~x;
            2'd1:    return x & y;
            2'd2:    return x | y;
            default: return XOR_EN ? (x ^ y) : 8'h00;
        endcase
    endfunction

    function automatic int exp_len(input logic [1:0] o);
        case (o)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 3;
            default: return XOR_EN ? 4 : 1;
        endcase
    endfunction

    // Model: phase 0 idle, 1 computing, 2 result held
    int         m_phase;
    int         m_left;
    int         m_cnt;
    logic       m_inc;
    logic [7:0] m_pend;
    logic       m_perr;
    logic [7:0] m_res;
    logic       m_err;
    logic       started;
    logic       do_preload;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_left  <= 0;
            m_cnt   <= 0;
            m_res   <= 8'h00;
            m_err   <= 1'b0;
        end else if (do_preload) begin
            m_cnt <= 32'hFFFE;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend  <= exp_res(op, a, b);
                    m_perr  <= (op == 2'd3) && !XOR_EN;
                    m_inc   <= !((op == 2'd3) && !XOR_EN);
                    m_left  <= exp_len(op);
                    m_phase <= 1;
                end
                1: begin
                    if (m_inc && m_cnt < 65535)
                        m_cnt <= m_cnt + 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_res   <= m_pend;
                        m_err   <= m_perr;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("busy", busy, m_phase != 0);
            chk("out_valid", out_valid, m_phase == 2);
            chk("nand_ops", nand_ops, m_cnt);
            chk("result", result, m_res);
            chk("err", err, m_err);
        end
    end

    task automatic run(input logic [1:0] o, input logic [7:0] x,
                       input logic [7:0] y, output int lat,
                       output logic [7:0] r, output logic e);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = result;
        e = err;
        if (out_ready)
            @(negedge clk);
    endtask

    int         lat;
    logic [7:0] r;
    logic       e;
    logic [7:0] hold;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = 2'd0;
        a = 8'h00;
        b = 8'h00;
        do_preload = 1'b0;
        started = 1'b0;
        @(negedge clk);
        @(negedge clk);
        started = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 8'h00);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_nand_ops", nand_ops, 0);
        rst = 1'b0;

        run(2'd0, 8'hA5, 8'h00, lat, r, e);
        chk("not_lat", lat, 1);
        chk("not_res", r, 8'h5A);
        chk("not_err", e, 0);
        chk("not_ops", nand_ops, 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run(2'd1, 8'hF0, 8'h3C, lat, r, e);
        chk("and_lat", lat, 2);
        chk("and_res", r, 8'h30);
        run(2'd2, 8'hF0, 8'h0F, lat, r, e);
        chk("or_lat", lat, 3);
        chk("or_res", r, 8'hFF);
        chk("or_ops", nand_ops, 5);

        run(2'd3, 8'hA5, 8'hFF, lat, r, e);
        chk("op3_lat", lat, XOR_EN ? 4 : 1);
        chk("op3_res", r, XOR_EN ? 8'h5A : 8'h00);
        chk("op3_err", e, XOR_EN ? 0 : 1);
        chk("op3_ops", nand_ops, XOR_EN ? 9 : 5);

        out_ready = 1'b0;
        run(2'd1, 8'hAA, 8'h0F, lat, r, e);
        chk("bp_res", r, 8'h0A);
        hold = r;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op = 2'd2;
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_hold", result, hold);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drop", out_valid, 0);
        chk("bp_idle", in_ready, 1);

        in_valid = 1'b1;
        op = 2'd2;
        a = 8'hF0;
        b = 8'h0F;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        op = 2'd0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_ops", nand_ops, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        run(2'd0, 8'h00, 8'h00, lat, r, e);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_res", r, 8'hFF);

        #1;
        force dut.cnt = 16'hFFFE;
        do_preload = 1'b1;
        @(negedge clk);
        #1;
        release dut.cnt;
        do_preload = 1'b0;
        run(2'd1, 8'h0F, 8'h0F, lat, r, e);
        chk("sat_res", r, 8'h0F);
        chk("sat_ops", nand_ops, 16'hFFFF);
        run(2'd0, 8'h3C, 8'h00, lat, r, e);
        chk("sat_hold", nand_ops, 16'hFFFF);
        chk("sat_not", r, 8'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/nand_gate_sequencer.md
NAND_GATE_SEQUENCER -- requirements
Module: nand_gate_sequencer

Interface
REQ-001 Parameter: none; data width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  request present on op/a/b.
REQ-005 in_ready  output  1  sequencer can accept a request.
REQ-006 op  input  2  00 NOT a, 01 AND, 10 OR, 11 XOR.
REQ-007 a  input  8  operand A.
REQ-008 b  input  8  operand B; ignored for NOT.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  8  computed value.
REQ-012 err  output  1  qualifies result; 1 = unsupported op.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 nand_ops  output  16  count of NAND micro-ops executed since reset.

Function
REQ-015 Datapath SHALL contain exactly one shared 8-bit bitwise NAND unit; all ops are built from sequential NAND micro-ops on it; no direct AND/OR/XOR operators on data.
REQ-016 FSM states: IDLE, EXEC, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready; on accept op/a/b are registered and FSM moves to EXEC with step = 0.
REQ-018 EXEC performs one NAND per cycle into temps s1..s3; micro-op sequences (N = step count):
  NOT (N=1): result = nand(a,a).
  AND (N=2): s1 = nand(a,b); result = nand(s1,s1).
  OR  (N=3): s1 = nand(a,a); s2 = nand(b,b); result = nand(s1,s2).
  XOR (N=4): s1 = nand(a,b); s2 = nand(a,s1); s3 = nand(b,s1); result = nand(s2,s3).
REQ-019 Latency: if accept occurs on edge k, out_valid SHALL be 1 after edge k+N; FSM moves EXEC->DONE on edge k+N.
REQ-020 In DONE, out_valid = 1 and result/err SHALL hold stable until out_valid && out_ready; on that edge FSM returns to IDLE and out_valid drops.
REQ-021 No request is accepted in the same cycle a result is consumed; minimum spacing between accepts is N+2 edges.
REQ-022 in_valid deasserting or operand changes during EXEC/DONE SHALL have no effect.
REQ-023 nand_ops increments by 1 on every EXEC cycle, saturates at 16'hFFFF, never wraps.
REQ-024 err = 0 for every supported op.

Reset
REQ-025 On rst = 1 at a clock edge: FSM = IDLE, in_ready = 1, out_valid = 0, result = 8'h00, err = 0, busy = 0, nand_ops = 0, temps cleared.
REQ-026 rst SHALL override any state, including mid-EXEC or DONE with result pending; the pending result is discarded.
REQ-027 A request with in_valid = 1 during a rst edge SHALL NOT be accepted.

Configuration
REQ-028 Macro NAND_GATE_SEQUENCER_XOR_EN: when defined, op 11 executes the XOR sequence of REQ-018.
REQ-029 When not defined, op 11 SHALL be accepted, take one EXEC cycle without a NAND micro-op (nand_ops unchanged), and enter DONE with result = 8'h00, err = 1.

Verification
REQ-030 NOT: a=8'hA5 -> result=8'h5A, err=0, out_valid 1 edge after accept, nand_ops=1.
REQ-031 AND a=8'hF0 b=8'h3C -> 8'h30 after 2 edges; OR a=8'hF0 b=8'h0F -> 8'hFF after 3 edges; nand_ops accumulates to 5.
REQ-032 op=11 a=8'hA5 b=8'hFF: with macro -> 8'h5A, err=0 after 4 edges; without -> 8'h00, err=1 after 1 edge.
REQ-033 Backpressure: out_ready=0 for 5 cycles after AND completes -> result, out_valid stable; in_ready=0 while in_valid=1 with new operands; result consumed on first out_ready=1 edge, IDLE next cycle.
REQ-034 rst asserted during step 2 of an OR -> next cycle out_valid=0, in_ready=1, nand_ops=0; following NOT a=8'h00 -> 8'hFF.
REQ-035 Saturation: preload by running 65535+ micro-ops (or force counter to 16'hFFFE) then an AND -> nand_ops = 16'hFFFF and remains.
